// File: rtl/collision_pkg.sv
// Shared types for the collision scanner: FSM state encoding and a lowest-set-bit helper.
// Pure declarations; no latency or backpressure of its own.
package collision_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_REPORT
    } state_t;

    // Index of the lowest set bit; 0 when the vector is empty. Covers masks up to 32 channels.
    function automatic int unsigned lowest_set_idx(input logic [31:0] v);
        lowest_set_idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) lowest_set_idx = i;
        end
    endfunction

endpackage

// File: rtl/collision_scanner_if.sv
// Position/bullet inputs and hit/lives status outputs of the collision scanner.
// Plain wires, no handshake: the scanner samples once per frame tick and never stalls the source.
interface collision_scanner_if #(
    parameter int unsigned X_W      = 5,
    parameter int unsigned Y_W      = 6,
    parameter int unsigned N_BULLET = 4,
    parameter int unsigned LIVES    = 3
);
    localparam int unsigned IDX_W   = (N_BULLET > 1) ? $clog2(N_BULLET) : 1;
    localparam int unsigned LIVES_W = $clog2(LIVES + 1);

    logic                      i_Restart;
    logic [X_W-1:0]            i_Player_x;
    logic [Y_W-1:0]            i_Player_y;
    logic [N_BULLET*X_W-1:0]   i_Bullet_x;
    logic [N_BULLET*Y_W-1:0]   i_Bullet_y;
    logic [N_BULLET-1:0]       i_Bullet_vld;

    logic                      o_fCollision;
    logic [IDX_W-1:0]          o_Hit_Idx;
    logic [N_BULLET-1:0]       o_Hit_Mask;
    logic [LIVES_W-1:0]        o_Lives;
    logic                      o_Invuln;
    logic                      o_Game_Over;
    logic                      o_Busy;

    modport master (
        output i_Restart, i_Player_x, i_Player_y, i_Bullet_x, i_Bullet_y, i_Bullet_vld,
        input  o_fCollision, o_Hit_Idx, o_Hit_Mask, o_Lives, o_Invuln, o_Game_Over, o_Busy
    );

    modport slave (
        input  i_Restart, i_Player_x, i_Player_y, i_Bullet_x, i_Bullet_y, i_Bullet_vld,
        output o_fCollision, o_Hit_Idx, o_Hit_Mask, o_Lives, o_Invuln, o_Game_Over, o_Busy
    );

endinterface

// File: rtl/frame_tick_gen.sv
// Free-running frame counter, one-cycle tick on the last count; tick is combinational from the count register.
// No backpressure: counts every clock regardless of downstream state.
module frame_tick_gen #(
    parameter int unsigned TICK_CNT = 800_000
) (
    input  logic i_Clk,
    input  logic i_Rst,
    output logic tick
);
    localparam int unsigned CNT_W = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;

    logic [CNT_W-1:0] cnt_q;

    assign tick = (cnt_q == CNT_W'(TICK_CNT - 1));

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/collision_scanner.sv
// Per-frame collision engine: snapshot on tick, scan one bullet/clock, report N_BULLET+2 cycles after tick; lives/invuln/game-over.
// No backpressure; i_Restart aborts any scan. COLLISION_HITBOX_EN widens hit test to a +/-HITBOX_R box.
module collision_scanner
    import collision_pkg::*;
#(
    parameter int unsigned X_W           = 5,
    parameter int unsigned Y_W           = 6,
    parameter int unsigned N_BULLET      = 4,
    parameter int unsigned TICK_CNT      = 800_000,
    parameter int unsigned LIVES         = 3,
    parameter int unsigned INVULN_FRAMES = 30,
    parameter int unsigned HITBOX_R      = 1
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    collision_scanner_if.slave   bus
);
    localparam int unsigned IDX_W   = (N_BULLET > 1) ? $clog2(N_BULLET) : 1;
    localparam int unsigned LIVES_W = $clog2(LIVES + 1);
    localparam int unsigned INV_W   = (INVULN_FRAMES > 0) ? $clog2(INVULN_FRAMES + 1) : 1;
`ifdef COLLISION_HITBOX_EN
    localparam int unsigned HIT_R   = HITBOX_R;
`else
    // Zero radius turns the window test into exact coordinate equality.
    localparam int unsigned HIT_R   = 0 * HITBOX_R;
`endif

    logic tick;

    frame_tick_gen #(.TICK_CNT(TICK_CNT)) u_tick (
        .i_Clk (i_Clk),
        .i_Rst (i_Rst),
        .tick  (tick)
    );

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q;
    logic [N_BULLET-1:0]     mask_q;
    logic [X_W-1:0]          px_q;
    logic [Y_W-1:0]          py_q;
    logic [N_BULLET*X_W-1:0] bx_q;
    logic [N_BULLET*Y_W-1:0] by_q;
    logic [N_BULLET-1:0]     bvld_q;
    logic                    fcoll_q;
    logic [IDX_W-1:0]        hit_idx_q;
    logic [N_BULLET-1:0]     hit_mask_q;
    logic [LIVES_W-1:0]      lives_q;
    logic [INV_W-1:0]        inv_cnt_q;
    logic                    game_over_q;

    logic [X_W-1:0] cur_bx;
    logic [Y_W-1:0] cur_by;
    logic [X_W:0]   dx;
    logic [Y_W:0]   dy;
    logic           hit_now;
    logic           last_idx;

    // Absolute distance one bit wider than the coordinate, so there is no wrap-around.
    always_comb begin
        cur_bx   = bx_q[idx_q*X_W +: X_W];
        cur_by   = by_q[idx_q*Y_W +: Y_W];
        dx       = (cur_bx >= px_q) ? ({1'b0, cur_bx} - {1'b0, px_q}) : ({1'b0, px_q} - {1'b0, cur_bx});
        dy       = (cur_by >= py_q) ? ({1'b0, cur_by} - {1'b0, py_q}) : ({1'b0, py_q} - {1'b0, cur_by});
        hit_now  = bvld_q[idx_q] && (dx <= (X_W+1)'(HIT_R)) && (dy <= (Y_W+1)'(HIT_R));
        last_idx = (idx_q == IDX_W'(N_BULLET - 1));
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (tick) state_d = ST_SCAN;
            ST_SCAN:   if (last_idx) state_d = ST_REPORT;
            ST_REPORT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (bus.i_Restart) state_d = ST_IDLE;
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            idx_q       <= '0;
            mask_q      <= '0;
            px_q        <= '0;
            py_q        <= '0;
            bx_q        <= '0;
            by_q        <= '0;
            bvld_q      <= '0;
            fcoll_q     <= 1'b0;
            hit_idx_q   <= '0;
            hit_mask_q  <= '0;
            lives_q     <= LIVES_W'(LIVES);
            inv_cnt_q   <= '0;
            game_over_q <= 1'b0;
        end else begin
            fcoll_q <= 1'b0;
            if (bus.i_Restart) begin
                idx_q       <= '0;
                mask_q      <= '0;
                hit_idx_q   <= '0;
                hit_mask_q  <= '0;
                lives_q     <= LIVES_W'(LIVES);
                inv_cnt_q   <= '0;
                game_over_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: if (tick) begin
                        px_q   <= bus.i_Player_x;
                        py_q   <= bus.i_Player_y;
                        bx_q   <= bus.i_Bullet_x;
                        by_q   <= bus.i_Bullet_y;
                        bvld_q <= bus.i_Bullet_vld;
                        idx_q  <= '0;
                        mask_q <= '0;
                    end
                    ST_SCAN: begin
                        if (hit_now) mask_q[idx_q] <= 1'b1;
                        if (!last_idx) idx_q <= idx_q + IDX_W'(1);
                    end
                    ST_REPORT: begin
                        hit_mask_q <= mask_q;
                        if (!game_over_q) begin
                            if (inv_cnt_q != '0) begin
                                inv_cnt_q <= inv_cnt_q - INV_W'(1);
                            end else if (|mask_q) begin
                                fcoll_q   <= 1'b1;
                                hit_idx_q <= IDX_W'(lowest_set_idx(32'(mask_q)));
                                lives_q   <= (lives_q == '0) ? '0 : lives_q - LIVES_W'(1);
                                inv_cnt_q <= INV_W'(INVULN_FRAMES);
                                if (lives_q <= LIVES_W'(1)) game_over_q <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.o_fCollision = fcoll_q;
    assign bus.o_Hit_Idx    = hit_idx_q;
    assign bus.o_Hit_Mask   = hit_mask_q;
    assign bus.o_Lives      = lives_q;
    assign bus.o_Invuln     = (inv_cnt_q != '0);
    assign bus.o_Game_Over  = game_over_q;
    assign bus.o_Busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_collision_scanner.sv
// Directed frame-by-frame bench for collision_scanner (TICK_CNT=16, N_BULLET=4, LIVES=3, INVULN_FRAMES=2, HITBOX_R=1).
module tb_collision_scanner;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

`ifdef COLLISION_HITBOX_EN
    localparam bit HB = 1'b1;
`else
    localparam bit HB = 1'b0;
`endif

    collision_scanner_if #(.X_W(5), .Y_W(6), .N_BULLET(4), .LIVES(3)) bus ();

    collision_scanner #(
        .X_W(5), .Y_W(6), .N_BULLET(4), .TICK_CNT(16),
        .LIVES(3), .INVULN_FRAMES(2), .HITBOX_R(1)
    ) dut (
        .i_Clk (clk),
        .i_Rst (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [4:0]  px;
        logic [5:0]  py;
        logic [19:0] bx;
        logic [23:0] by;
        logic [3:0]  vld;
        bit          restart_mid;
        bit          e_pulse;
        logic [1:0]  e_idx;
        logic [3:0]  e_mask;
        logic [1:0]  e_lives;
        bit          e_inv;
        bit          e_go;
        int          e_busy;
    } vec_t;

    vec_t vt[19];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input int f, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (frame %0d): got %0h, want %0h", name, f, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [4:0] px, input logic [5:0] py,
                                input logic [19:0] bx, input logic [23:0] by, input logic [3:0] vld,
                                input bit rm, input bit p, input logic [1:0] idx, input logic [3:0] mask,
                                input logic [1:0] lives, input bit inv, input bit go, input int busy);
        vec_t v;
        v.px = px; v.py = py; v.bx = bx; v.by = by; v.vld = vld;
        v.restart_mid = rm; v.e_pulse = p; v.e_idx = idx; v.e_mask = mask;
        v.e_lives = lives; v.e_inv = inv; v.e_go = go; v.e_busy = busy;
        return v;
    endfunction

    // Bullet sets, channel 0 in the low bits.
    localparam logic [19:0] BX_A = {5'd31, 5'd10, 5'd3,  5'd0};   // b2 on (10,20)
    localparam logic [23:0] BY_A = {6'd63, 6'd20, 6'd5,  6'd0};
    localparam logic [19:0] BX_B = {5'd10, 5'd20, 5'd10, 5'd0};   // b1, b3 on (10,20)
    localparam logic [23:0] BY_B = {6'd20, 6'd40, 6'd20, 6'd0};
    localparam logic [19:0] BX_C = {5'd31, 5'd20, 5'd3,  5'd10};  // b0 on (10,20)
    localparam logic [23:0] BY_C = {6'd63, 6'd40, 6'd5,  6'd20};
    localparam logic [19:0] BX_D = {5'd10, 5'd20, 5'd3,  5'd0};   // b3 on (10,20)
    localparam logic [23:0] BY_D = {6'd20, 6'd40, 6'd5,  6'd0};
    localparam logic [19:0] BX_E = {5'd31, 5'd0,  5'd12, 5'd11};  // b0 at (11,21), b1 at (12,22)
    localparam logic [23:0] BY_E = {6'd63, 6'd0,  6'd22, 6'd21};
    localparam logic [19:0] BX_F = 20'd0;                         // b0 at (0,20)
    localparam logic [23:0] BY_F = {6'd0, 6'd0, 6'd0, 6'd20};

    int busy_cnt;
    int stray;

    initial begin
        //            px     py     bx    by    vld      rm  p  idx    mask      lives inv go busy
        vt[0]  = mk(5'd10, 6'd20, BX_A, BY_A, 4'b0000, 0, 0, 2'd0, 4'b0000, 2'd3, 0, 0, 5);
        vt[1]  = mk(5'd10, 6'd20, BX_A, BY_A, 4'b1011, 0, 0, 2'd0, 4'b0000, 2'd3, 0, 0, 5);
        vt[2]  = mk(5'd10, 6'd20, BX_A, BY_A, 4'b1111, 0, 1, 2'd2, 4'b0100, 2'd2, 1, 0, 5);
        vt[3]  = mk(5'd10, 6'd20, BX_A, BY_A, 4'b1111, 0, 0, 2'd2, 4'b0100, 2'd2, 1, 0, 5);
        vt[4]  = mk(5'd10, 6'd20, BX_A, BY_A, 4'b1111, 0, 0, 2'd2, 4'b0100, 2'd2, 0, 0, 5);
        vt[5]  = mk(5'd10, 6'd20, BX_A, BY_A, 4'b1111, 0, 1, 2'd2, 4'b0100, 2'd1, 1, 0, 5);
        vt[6]  = mk(5'd10, 6'd20, BX_A, BY_A, 4'b0000, 0, 0, 2'd2, 4'b0000, 2'd1, 1, 0, 5);
        vt[7]  = mk(5'd10, 6'd20, BX_A, BY_A, 4'b0000, 0, 0, 2'd2, 4'b0000, 2'd1, 0, 0, 5);
        vt[8]  = mk(5'd10, 6'd20, BX_B, BY_B, 4'b1111, 0, 1, 2'd1, 4'b1010, 2'd0, 1, 1, 5);
        vt[9]  = mk(5'd10, 6'd20, BX_B, BY_B, 4'b1111, 0, 0, 2'd1, 4'b1010, 2'd0, 1, 1, 5);
        vt[10] = mk(5'd10, 6'd20, BX_C, BY_C, 4'b1111, 0, 0, 2'd1, 4'b0001, 2'd0, 1, 1, 5);
        vt[11] = mk(5'd10, 6'd20, BX_C, BY_C, 4'b1111, 1, 0, 2'd0, 4'b0000, 2'd3, 0, 0, 2);
        vt[12] = mk(5'd10, 6'd20, BX_D, BY_D, 4'b1111, 0, 1, 2'd3, 4'b1000, 2'd2, 1, 0, 5);
        vt[13] = mk(5'd10, 6'd20, BX_D, BY_D, 4'b0000, 0, 0, 2'd3, 4'b0000, 2'd2, 1, 0, 5);
        vt[14] = mk(5'd10, 6'd20, BX_D, BY_D, 4'b0000, 0, 0, 2'd3, 4'b0000, 2'd2, 0, 0, 5);
        vt[15] = mk(5'd10, 6'd20, BX_E, BY_E, 4'b0011, 0, HB, HB ? 2'd0 : 2'd3,
                    HB ? 4'b0001 : 4'b0000, HB ? 2'd1 : 2'd2, HB, 0, 5);
        vt[16] = mk(5'd10, 6'd20, BX_A, BY_A, 4'b0000, 0, 0, HB ? 2'd0 : 2'd3,
                    4'b0000, HB ? 2'd1 : 2'd2, HB, 0, 5);
        vt[17] = mk(5'd10, 6'd20, BX_A, BY_A, 4'b0000, 0, 0, HB ? 2'd0 : 2'd3,
                    4'b0000, HB ? 2'd1 : 2'd2, 0, 0, 5);
        vt[18] = mk(5'd31, 6'd20, BX_F, BY_F, 4'b0001, 0, 0, HB ? 2'd0 : 2'd3,
                    4'b0000, HB ? 2'd1 : 2'd2, 0, 0, 5);

        bus.i_Restart    = 1'b0;
        bus.i_Player_x   = '0;
        bus.i_Player_y   = '0;
        bus.i_Bullet_x   = '0;
        bus.i_Bullet_y   = '0;
        bus.i_Bullet_vld = '0;

        #23;
        @(negedge clk);
        chk("reset fCollision", -1, 32'(bus.o_fCollision), 32'd0);
        chk("reset Hit_Idx",    -1, 32'(bus.o_Hit_Idx),    32'd0);
        chk("reset Hit_Mask",   -1, 32'(bus.o_Hit_Mask),   32'd0);
        chk("reset Lives",      -1, 32'(bus.o_Lives),      32'd3);
        chk("reset Invuln",     -1, 32'(bus.o_Invuln),     32'd0);
        chk("reset Game_Over",  -1, 32'(bus.o_Game_Over),  32'd0);
        chk("reset Busy",       -1, 32'(bus.o_Busy),       32'd0);
        rst_n = 1'b1;

        // Counter is 0 here; 15 more cycles lands in the first tick cycle.
        stray = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.o_Busy || bus.o_fCollision) stray++;
        end
        chk("idle before first tick", -1, 32'(stray), 32'd0);

        for (int f = 0; f < 19; f++) begin
            bus.i_Player_x   = vt[f].px;
            bus.i_Player_y   = vt[f].py;
            bus.i_Bullet_x   = vt[f].bx;
            bus.i_Bullet_y   = vt[f].by;
            bus.i_Bullet_vld = vt[f].vld;
            busy_cnt = 0;
            stray    = 0;
            for (int i = 1; i <= 16; i++) begin
                @(negedge clk);
                if (bus.o_Busy) busy_cnt++;
                if (i == 6) begin
                    chk("fCollision", f, 32'(bus.o_fCollision), 32'(vt[f].e_pulse));
                    chk("Hit_Idx",    f, 32'(bus.o_Hit_Idx),    32'(vt[f].e_idx));
                    chk("Hit_Mask",   f, 32'(bus.o_Hit_Mask),   32'(vt[f].e_mask));
                    chk("Lives",      f, 32'(bus.o_Lives),      32'(vt[f].e_lives));
                    chk("Invuln",     f, 32'(bus.o_Invuln),     32'(vt[f].e_inv));
                    chk("Game_Over",  f, 32'(bus.o_Game_Over),  32'(vt[f].e_go));
                end else if (bus.o_fCollision) begin
                    stray++;
                end
                // After the snapshot edge: inputs that would all collide if re-sampled.
                if (i == 1) begin
                    bus.i_Player_x   = '0;
                    bus.i_Player_y   = '0;
                    bus.i_Bullet_x   = '0;
                    bus.i_Bullet_y   = '0;
                    bus.i_Bullet_vld = 4'b1111;
                end
                if (i == 2 && vt[f].restart_mid) bus.i_Restart = 1'b1;
                if (i == 3) bus.i_Restart = 1'b0;
            end
            chk("busy cycles",  f, 32'(busy_cnt), 32'(vt[f].e_busy));
            chk("stray pulses", f, 32'(stray),    32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
